lut_eval_bank: RTL and testbench
================================

Name: lut_eval_bank

Overview:
Programmable multi-channel boolean function evaluator, the generalised successor of the fixed 4-input sum/product-of-sums blocks.
- Each channel holds a 2^N_IN-entry truth table written over a config port.
- Evaluates any N_IN-bit input vector with one-cycle registered latency.
- A sweep engine walks all input combinations and reports each channel's minterm count.
- Used in the lab top level for checking and counting user-entered logic functions.

Parameters:
N_IN, 4, number of function inputs; truth table depth is 2^N_IN (legal range 2..6)
N_CH, 2, number of independent channels/functions (legal range 1..8)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cfg_we  input  1  truth-table bit write strobe
cfg_ch  input  $clog2(N_CH) (min 1)  channel select for write
cfg_addr  input  N_IN  table index (equals the input vector value)
cfg_data  input  1  bit value to write
cfg_err  output  1  one-cycle pulse: write rejected
in_valid  input  1  evaluate request
in_vec  input  N_IN  input vector; bit N_IN-1 is MSB (w-style), bit 0 is LSB
out_valid  output  1  result valid, one cycle after in_valid
out_vec  output  N_CH  bit c = table_c[in_vec]
start  input  1  begin minterm sweep
busy  output  1  sweep in progress
done  output  1  one-cycle pulse at end of sweep
cnt_flat  output  N_CH*(N_IN+1)  channel c count at bits [c*(N_IN+1) +: N_IN+1]

Behaviour:
- Reset (async, rst=1): all truth tables cleared to 0; state=IDLE; sweep index=0. Outputs out_valid, out_vec, busy, done, cfg_err and cnt_flat all read 0.
- Storage: flop array, N_CH x 2^N_IN bits; combinational read, synchronous write.
- Config write: on a clk edge with cfg_we=1 and state IDLE, table[cfg_ch][cfg_addr] <= cfg_data.
- Rejected write: cfg_we=1 while busy, or cfg_ch >= N_CH. Table is unchanged and cfg_err=1 for the next cycle.
- Evaluate: in_valid sampled at edge k. At edge k+1, out_valid=1 and out_vec holds the table contents as of edge k; a write at the same edge is not visible until the next evaluation.
  - out_valid deasserts the cycle after in_valid drops.
  - out_vec holds its last value when out_valid=0.
  - Evaluation is independent of sweep state and allowed while busy.
- Sweep FSM: IDLE, SWEEP, DONE.
  - IDLE: start=1 -> SWEEP; idx<=0; all counts cleared to 0.
  - SWEEP: busy=1. Each cycle, every count_c += table_c[idx] and idx++. On the idx=2^N_IN-1 cycle -> DONE.
  - DONE: done=1 and busy=0 for exactly one cycle -> IDLE.
  - Timing: start at edge 0 gives busy for 2^N_IN cycles, then done on the next cycle. Total 2^N_IN+1 cycles (17 for N_IN=4).
- start while busy or in DONE is ignored (no restart).
- Counts are N_IN+1 bits, so the all-ones table gives 2^N_IN with no overflow. Counts hold after DONE until the next start.
- Simultaneous events:
  - start together with cfg_we in IDLE: the write takes effect and the sweep sees the new value.
  - Writes during SWEEP are rejected (see cfg_err).
- Reset mid-sweep: immediate return to IDLE; counts 0; no done pulse; tables cleared.
- idx is N_IN bits and wraps to 0 on the final SWEEP cycle; no other wrap-around.

Decomposition:
- Package lut_eval_pkg: state encoding (IDLE=2'd0, SWEEP=2'd1, DONE=2'd2), function DEPTH(n)=1<<n, count-width function n+1.
- Sub-module lut_chan: one channel's table storage, write enable, read mux and popcount accumulator. Generated N_CH times.
- Top level holds the FSM, idx, cfg decode and the output registers.

Test Plan:
- Reset with in_valid=1 held -> out_valid=0, out_vec=0, cnt_flat=0; after release, first evaluation returns 0.
- Program ch0=16'h8000 (AND4) and ch1=16'h7FFE (not all-equal), then in_vec=4'hF, 4'h0, 4'h5 -> out_vec=2'b01, 2'b00, 2'b10, each one cycle after in_valid.
- With the same tables, pulse start -> busy high 16 cycles, done a single cycle at cycle 17, cnt0=5'd1, cnt1=5'd14. Program ch0 all ones and sweep -> cnt0=5'd16.
- cfg_we=1 during SWEEP -> cfg_err pulse; table unchanged; a later evaluation returns the old bit. Second start while busy is ignored, giving a single done.
- Assert rst at cycle 8 of a sweep -> busy=0 immediately, no done pulse, counts 0, all evaluations return 0.
- N_IN=2, N_CH=1 build, table 4'b0110 (XOR) -> evaluations 00,01,10,11 give 0,1,1,0; sweep gives busy 4 cycles and cnt=3'd2.

Source files
------------

// File: rtl/lut_eval_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lut_eval_pkg
//  Description : Shared sweep-FSM state encoding and sizing helpers for the
//                programmable truth-table evaluator bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package lut_eval_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Number of truth-table entries for an n-input function.
  function automatic int DEPTH(input int n);
    return 1 << n;
  endfunction

  // Minterm counter width: one extra bit so an all-ones table fits.
  function automatic int CNT_W(input int n);
    return n + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lut_eval_bank_chan.sv
`default_nettype none
// ============================================================================
//  Module      : lut_chan
//  Description : One channel: truth-table flops, write port, combinational
//                read mux and the minterm popcount accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_chan
  import lut_eval_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [N_IN-1:0]          wr_addr,
  input  logic                     wr_data,
  input  logic [N_IN-1:0]          rd_addr,
  output logic                     rd_data,
  input  logic [N_IN-1:0]          sweep_idx,
  input  logic                     cnt_clr,
  input  logic                     cnt_en,
  output logic [CNT_W(N_IN)-1:0]   cnt
);

  localparam int TBL_D = DEPTH(N_IN);
  localparam int CW    = CNT_W(N_IN);

  logic [TBL_D-1:0] tbl_q, tbl_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Next table contents: a single qualified bit write per cycle.
  always_comb begin
    tbl_d = tbl_q;
    if (wr_en) tbl_d[wr_addr] = wr_data;
  end

  // Next count: clear on sweep start, accumulate the indexed bit while sweeping.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)     cnt_d = '0;
    else if (cnt_en) cnt_d = cnt_q + CW'(tbl_q[sweep_idx]);
  end

  // Table and counter state; reset clears every entry and the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_q <= '0;
      cnt_q <= '0;
    end else begin
      tbl_q <= tbl_d;
      cnt_q <= cnt_d;
    end
  end

  // Reads see the pre-edge table, so a same-edge write is not yet visible.
  assign rd_data = tbl_q[rd_addr];
  assign cnt     = cnt_q;

endmodule
`default_nettype wire

// File: rtl/lut_eval_bank.sv
`default_nettype none
// ============================================================================
//  Module      : lut_eval_bank
//  Description : Multi-channel programmable boolean evaluator with registered
//                evaluation and a minterm-counting sweep engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_eval_bank
  import lut_eval_pkg::*;
#(
  parameter  int N_IN = 4,
  parameter  int N_CH = 2,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CW   = N_IN + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [N_IN-1:0]      cfg_addr,
  input  logic                 cfg_data,
  output logic                 cfg_err,
  input  logic                 in_valid,
  input  logic [N_IN-1:0]      in_vec,
  output logic                 out_valid,
  output logic [N_CH-1:0]      out_vec,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [N_CH*CW-1:0]   cnt_flat
);

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic              cfg_err_q, cfg_err_d;
  logic              out_valid_q, out_valid_d;
  logic [N_CH-1:0]   out_vec_q, out_vec_d;

  logic              w_ch_ok;
  logic              w_wr_ok;
  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic [N_CH-1:0]   w_rd_vec;

  // Writes land only in IDLE and only to an existing channel.
  assign w_ch_ok = (32'(cfg_ch) < 32'(N_CH));
  assign w_wr_ok = cfg_we && (state_q == IDLE) && w_ch_ok;

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_chan
      logic [CW-1:0] w_cnt;

      lut_chan #(
        .N_IN (N_IN)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (w_wr_ok && (cfg_ch == CH_W'(c))),
        .wr_addr   (cfg_addr),
        .wr_data   (cfg_data),
        .rd_addr   (in_vec),
        .rd_data   (w_rd_vec[c]),
        .sweep_idx (idx_q),
        .cnt_clr   (w_cnt_clr),
        .cnt_en    (w_cnt_en),
        .cnt       (w_cnt)
      );

      assign cnt_flat[c*CW +: CW] = w_cnt;
    end
  endgenerate

  // Sweep sequencing: IDLE -> SWEEP (one entry per cycle) -> DONE -> IDLE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SWEEP;
          idx_d     = '0;
          w_cnt_clr = 1'b1;
        end
      end
      SWEEP: begin
        w_cnt_en = 1'b1;
        idx_d    = idx_q + 1'b1;   // wraps to 0 on the last entry
        if (idx_q == '1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Error pulse and registered evaluation result; out_vec holds when idle.
  always_comb begin
    cfg_err_d   = cfg_we && !w_wr_ok;
    out_valid_d = in_valid;
    out_vec_d   = in_valid ? w_rd_vec : out_vec_q;
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
      out_vec_q   <= out_vec_d;
    end
  end

  assign busy      = (state_q == SWEEP);
  assign done      = (state_q == DONE);
  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_eval_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lut_eval_bank
//  Description : Directed bench for lut_eval_bank (4-in/2-ch and 2-in/1-ch).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_eval_bank;

  logic clk = 1'b0;
  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // 4-input, 2-channel instance
  logic       rst, cfg_we, cfg_ch, cfg_data, cfg_err;
  logic [3:0] cfg_addr, in_vec;
  logic       in_valid, out_valid, start, busy, done;
  logic [1:0] out_vec;
  logic [9:0] cnt_flat;

  // 2-input, 1-channel instance
  logic       rst2, cfg_we2, cfg_ch2, cfg_data2, cfg_err2;
  logic [1:0] cfg_addr2, in_vec2;
  logic       in_valid2, out_valid2, start2, busy2, done2;
  logic [0:0] out_vec2;
  logic [2:0] cnt_flat2;

  int n_checks = 0;
  int n_fail   = 0;

  lut_eval_bank #(.N_IN(4), .N_CH(2)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .in_valid(in_valid), .in_vec(in_vec),
    .out_valid(out_valid), .out_vec(out_vec), .start(start), .busy(busy),
    .done(done), .cnt_flat(cnt_flat)
  );

  lut_eval_bank #(.N_IN(2), .N_CH(1)) dut2 (
    .clk(clk), .rst(rst2), .cfg_we(cfg_we2), .cfg_ch(cfg_ch2), .cfg_addr(cfg_addr2),
    .cfg_data(cfg_data2), .cfg_err(cfg_err2), .in_valid(in_valid2), .in_vec(in_vec2),
    .out_valid(out_valid2), .out_vec(out_vec2), .start(start2), .busy(busy2),
    .done(done2), .cnt_flat(cnt_flat2)
  );

  typedef struct { logic [3:0] vin; logic [1:0] exp; } ev4_t;
  typedef struct { logic [1:0] vin; logic       exp; } ev2_t;
  ev4_t ev4[6];
  ev2_t ev2[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic ch, input logic [3:0] a, input logic d);
    cfg_we = 1'b1; cfg_ch = ch; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load_table(input logic ch, input logic [15:0] tt);
    for (int i = 0; i < 16; i++) wr(ch, 4'(i), tt[i]);
  endtask

  task automatic wr2(input logic ch, input logic [1:0] a, input logic d);
    cfg_we2 = 1'b1; cfg_ch2 = ch; cfg_addr2 = a; cfg_data2 = d;
    tick();
    cfg_we2 = 1'b0;
  endtask

  task automatic eval(input logic [3:0] v);
    in_valid = 1'b1; in_vec = v;
    tick();
    in_valid = 1'b0;
  endtask

  // Pulse start (optionally with a same-cycle write to ch1[0]=1), then watch
  // a bounded window; optionally re-pulse start / attempt a ch0[15]=0 write.
  task automatic sweep(input int restart_cyc, input int wr_cyc, input logic wr_at_start,
                       output int nbusy, output int ndone, output int done_at, output int nerr);
    nbusy = 0; ndone = 0; done_at = 0; nerr = 0;
    start = 1'b1;
    if (wr_at_start) begin cfg_we = 1'b1; cfg_ch = 1'b1; cfg_addr = 4'h0; cfg_data = 1'b1; end
    tick();
    start = 1'b0; cfg_we = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (busy) nbusy++;
      if (done) begin ndone++; done_at = cyc; end
      if (cfg_err) nerr++;
      if (cyc == restart_cyc) start = 1'b1;
      if (cyc == wr_cyc) begin cfg_we = 1'b1; cfg_ch = 1'b0; cfg_addr = 4'hF; cfg_data = 1'b0; end
      tick();
      start = 1'b0; cfg_we = 1'b0;
    end
  endtask

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nd, da, ne;

    ev4[0] = '{4'hF, 2'b01}; ev4[1] = '{4'h0, 2'b00}; ev4[2] = '{4'h5, 2'b10};
    ev4[3] = '{4'hA, 2'b10}; ev4[4] = '{4'hE, 2'b10}; ev4[5] = '{4'h1, 2'b10};
    ev2[0] = '{2'b00, 1'b0}; ev2[1] = '{2'b01, 1'b1};
    ev2[2] = '{2'b10, 1'b1}; ev2[3] = '{2'b11, 1'b0};

    cfg_we = 0; cfg_ch = 0; cfg_addr = 0; cfg_data = 0; start = 0;
    cfg_we2 = 0; cfg_ch2 = 0; cfg_addr2 = 0; cfg_data2 = 0; start2 = 0;
    in_valid2 = 0; in_vec2 = 0;
    rst = 1'b1; rst2 = 1'b1;
    in_valid = 1'b1; in_vec = 4'hF;

    // Reset held with in_valid asserted
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_vec",   32'(out_vec),   32'(0));
    check("rst_cnt_flat",  32'(cnt_flat),  32'(0));
    check("rst_busy",      32'(busy),      32'(0));
    check("rst_done",      32'(done),      32'(0));
    check("rst_cfg_err",   32'(cfg_err),   32'(0));
    rst = 1'b0; rst2 = 1'b0;
    tick();
    in_valid = 1'b0;
    check("first_eval_valid", 32'(out_valid), 32'(1));
    check("first_eval_vec",   32'(out_vec),   32'(0));

    // Program AND4 on ch0 and not-all-equal on ch1, then evaluate back-to-back
    load_table(1'b0, 16'h8000);
    load_table(1'b1, 16'h7FFE);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_vec = ev4[i].vin;
      tick();
      check($sformatf("eval_valid[%0d]", i), 32'(out_valid), 32'(1));
      check($sformatf("eval_vec[%0d]", i),   32'(out_vec),   32'(ev4[i].exp));
    end
    in_valid = 1'b0;
    tick();
    check("valid_drop", 32'(out_valid), 32'(0));
    check("vec_hold",   32'(out_vec),   32'(2'b10));

    // Write on the same edge as an evaluation is seen only by the next one
    in_valid = 1'b1; in_vec = 4'h0;
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_addr = 4'h0; cfg_data = 1'b1;
    tick();
    cfg_we = 1'b0;
    check("same_edge_old", 32'(out_vec), 32'(2'b00));
    tick();
    in_valid = 1'b0;
    check("same_edge_new", 32'(out_vec), 32'(2'b01));
    wr(1'b0, 4'h0, 1'b0);

    // Sweep with an ignored restart and a rejected mid-sweep write
    sweep(3, 5, 1'b0, nb, nd, da, ne);
    check("sweep_busy_cycles", 32'(nb), 32'(16));
    check("sweep_done_count",  32'(nd), 32'(1));
    check("sweep_done_cycle",  32'(da), 32'(17));
    check("sweep_cfg_err",     32'(ne), 32'(1));
    check("sweep_cnt0", 32'(cnt_flat[4:0]), 32'(1));
    check("sweep_cnt1", 32'(cnt_flat[9:5]), 32'(14));
    eval(4'hF);
    check("rejected_write_kept", 32'(out_vec), 32'(2'b01));

    // All-ones ch0; start alongside a ch1[0]=1 write the sweep must see
    load_table(1'b0, 16'hFFFF);
    sweep(0, 0, 1'b1, nb, nd, da, ne);
    check("ones_cnt0", 32'(cnt_flat[4:0]), 32'(16));
    check("ones_cnt1", 32'(cnt_flat[9:5]), 32'(15));
    check("ones_no_err", 32'(ne), 32'(0));

    // Reset in the middle of a sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("mid_busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    #1;
    check("mid_busy_after", 32'(busy),     32'(0));
    check("mid_cnt_flat",   32'(cnt_flat), 32'(0));
    nd = 0;
    repeat (2) begin tick(); if (done) nd++; end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (done) nd++; end
    check("mid_no_done", 32'(nd), 32'(0));
    eval(4'hF);
    check("mid_eval_F", 32'(out_vec), 32'(2'b00));
    eval(4'h5);
    check("mid_eval_5", 32'(out_vec), 32'(2'b00));

    // Small build: out-of-range channel rejected, XOR table, 4-entry sweep
    wr2(1'b1, 2'b00, 1'b1);
    check("n2_bad_ch_err", 32'(cfg_err2), 32'(1));
    tick();
    check("n2_err_pulse_end", 32'(cfg_err2), 32'(0));
    wr2(1'b0, 2'b01, 1'b1);
    wr2(1'b0, 2'b10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1'b1; in_vec2 = ev2[i].vin;
      tick();
      check($sformatf("n2_eval[%0d]", i), 32'(out_vec2), 32'(ev2[i].exp));
    end
    in_valid2 = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    nb = 0; da = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (busy2) nb++;
      if (done2 && da == 0) da = cyc;
      tick();
    end
    check("n2_busy_cycles", 32'(nb),        32'(4));
    check("n2_done_cycle",  32'(da),        32'(5));
    check("n2_cnt",         32'(cnt_flat2), 32'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
